alu_sequencer: RTL and testbench

Hard-wired control sequencer that drives the CPU datapath through fetch and execute for register-format ALU instructions. It replaces the hand-sequenced control signals the datapath benches apply today: it produces every bus-select, register-enable, PC-increment, memory-read and ALU-op signal the datapath consumes, and it reads back the instruction register contents. It sits directly upstream of `datapath`, one control word per clock.

---
 rtl/alu_sequencer_if.sv | 34 +++
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Control bundle between the ALU sequencer and the datapath.
// The master side (sequencer) reads run/ir and drives every control signal.
interface alu_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic [4:0]  BusDataSelect;
  logic [3:0]  GP_addr;
  logic        e_PC;
  logic        e_IR;
  logic        e_Y;
  logic        e_Z;
  logic        e_HI;
  logic        e_LO;
  logic        e_MDR;
  logic        e_MAR;
  logic        e_GP;
  logic        incPC;
  logic        MDR_read;
  logic [3:0]  ALU_op;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, ir,
    output BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
    output incPC, MDR_read, ALU_op, halted, illegal
  );

  modport slave (
    output run, ir,
    input  BusDataSelect, GP_addr, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP,
    input  incPC, MDR_read, ALU_op, halted, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Hard-wired fetch/execute sequencer for register-format ALU instructions.
// Emits one datapath control word per clock, decoded from the state and ir.
module alu_sequencer (
  input  logic             clock,
  input  logic             clear,
  alu_sequencer_if.master  bus
);

  localparam logic [3:0] StIdle = 4'd0;
  localparam logic [3:0] StT0   = 4'd1;
  localparam logic [3:0] StT1   = 4'd2;
  localparam logic [3:0] StT2   = 4'd3;
  localparam logic [3:0] StT3   = 4'd4;
  localparam logic [3:0] StT4   = 4'd5;
  localparam logic [3:0] StT5   = 4'd6;
  localparam logic [3:0] StT6   = 4'd7;
  localparam logic [3:0] StHalt = 4'd8;

  localparam logic [4:0] SelZHi = 5'd18;
  localparam logic [4:0] SelZLo = 5'd19;
  localparam logic [4:0] SelPc  = 5'd20;
  localparam logic [4:0] SelMdr = 5'd21;

  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;

  // Instruction fields
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_binary, is_unary, is_muldiv, is_nop, is_halt;
  logic [3:0] end_state;
  logic       unused_ir;

  assign opcode    = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign unused_ir = ^bus.ir[14:0];

  assign is_binary = (opcode <= 5'd10);
  assign is_unary  = (opcode == 5'd11) || (opcode == 5'd12);
  assign is_muldiv = (opcode == 5'd9) || (opcode == 5'd10);
  assign is_nop    = (opcode == 5'd13);
  assign is_halt   = (opcode == 5'd14);

  // Last step of an instruction: chain straight into the next fetch when run is held
  assign end_state = bus.run ? StT0 : StIdle;

  // Next-state and illegal-flag logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: state_d = bus.run ? StT0 : StIdle;
      StT0:   state_d = StT1;
      StT1:   state_d = StT2;
      StT2:   state_d = StT3;
      StT3: begin
        if (is_binary || is_unary) begin
          state_d = StT4;
        end else if (is_nop) begin
          state_d = end_state;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StT4:   state_d = is_binary ? StT5 : end_state;
      StT5:   state_d = is_muldiv ? StT6 : end_state;
      StT6:   state_d = end_state;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous clear; HALT is only left through clear
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Control word decode; everything not named for a state stays 0
  always_comb begin
    bus.BusDataSelect = 5'd0;
    bus.GP_addr       = 4'd0;
    bus.e_PC          = 1'b0;
    bus.e_IR          = 1'b0;
    bus.e_Y           = 1'b0;
    bus.e_Z           = 1'b0;
    bus.e_HI          = 1'b0;
    bus.e_LO          = 1'b0;
    bus.e_MDR         = 1'b0;
    bus.e_MAR         = 1'b0;
    bus.e_GP          = 1'b0;
    bus.incPC         = 1'b0;
    bus.MDR_read      = 1'b0;
    bus.ALU_op        = 4'd0;
    bus.halted        = 1'b0;
    bus.illegal       = 1'b0;
    case (state_q)
      StT0: begin
        bus.BusDataSelect = SelPc;
        bus.e_MAR         = 1'b1;
        bus.incPC         = 1'b1;
        bus.e_Z           = 1'b1;
      end
      StT1: begin
        bus.BusDataSelect = SelZLo;
        bus.e_PC          = 1'b1;
        bus.MDR_read      = 1'b1;
        bus.e_MDR         = 1'b1;
      end
      StT2: begin
        bus.BusDataSelect = SelMdr;
        bus.e_IR          = 1'b1;
      end
      StT3: begin
        if (is_binary) begin
          bus.BusDataSelect = {1'b0, rb};
          bus.e_Y           = 1'b1;
        end else if (is_unary) begin
          // Unary ops need no Y operand, so the ALU result goes straight to Z
          bus.BusDataSelect = {1'b0, rb};
          bus.ALU_op        = opcode[3:0];
          bus.e_Z           = 1'b1;
        end
      end
      StT4: begin
        if (is_binary) begin
          bus.BusDataSelect = {1'b0, rc};
          bus.ALU_op        = opcode[3:0];
          bus.e_Z           = 1'b1;
        end else if (is_unary) begin
          bus.BusDataSelect = SelZLo;
          bus.GP_addr       = ra;
          bus.e_GP          = 1'b1;
        end
      end
      StT5: begin
        bus.BusDataSelect = SelZLo;
        if (is_muldiv) begin
          bus.e_LO = 1'b1;
        end else begin
          bus.GP_addr = ra;
          bus.e_GP    = 1'b1;
        end
      end
      StT6: begin
        bus.BusDataSelect = SelZHi;
        bus.e_HI          = 1'b1;
      end
      StHalt: begin
        bus.halted  = 1'b1;
        bus.illegal = illegal_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes the expected control word
// for each cycle, a monitor pops and compares it on the falling edge.
module tb_alu_sequencer;

  logic clock;
  logic clear;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Enable mask: {e_PC,e_IR,e_Y,e_Z,e_HI,e_LO,e_MDR,e_MAR,e_GP,incPC,MDR_read}
  localparam logic [10:0] EPc    = 11'h400;
  localparam logic [10:0] EIr    = 11'h200;
  localparam logic [10:0] EY     = 11'h100;
  localparam logic [10:0] EZ     = 11'h080;
  localparam logic [10:0] EHi    = 11'h040;
  localparam logic [10:0] ELo    = 11'h020;
  localparam logic [10:0] EMdr   = 11'h010;
  localparam logic [10:0] EMar   = 11'h008;
  localparam logic [10:0] EGp    = 11'h004;
  localparam logic [10:0] EInc   = 11'h002;
  localparam logic [10:0] EMdrRd = 11'h001;

  // Word layout: {halted, illegal, BusDataSelect, GP_addr, ALU_op, enables}
  function automatic logic [25:0] cw(input logic [4:0] bds, input logic [3:0] gp,
                                     input logic [3:0] alu, input logic [10:0] en,
                                     input logic h, input logic il);
    return {h, il, bds, gp, alu, en};
  endfunction

  function automatic logic [31:0] instr(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  localparam logic [25:0] WIdle = 26'd0;
  localparam logic [25:0] WT0   = {2'b00, 5'd20, 4'd0, 4'd0, EMar | EInc | EZ};
  localparam logic [25:0] WT1   = {2'b00, 5'd19, 4'd0, 4'd0, EPc | EMdrRd | EMdr};
  localparam logic [25:0] WT2   = {2'b00, 5'd21, 4'd0, 4'd0, EIr};

  typedef struct {
    logic        care;
    logic [25:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   fails;

  logic [25:0] obs;
  assign obs = {bus.halted, bus.illegal, bus.BusDataSelect, bus.GP_addr, bus.ALU_op,
                bus.e_PC, bus.e_IR, bus.e_Y, bus.e_Z, bus.e_HI, bus.e_LO, bus.e_MDR,
                bus.e_MAR, bus.e_GP, bus.incPC, bus.MDR_read};

  // Monitor: one control word per cycle, compared away from the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.care) begin
          checks++;
          if (obs !== e.exp) begin
            fails++;
            $display("FAIL %s: observed %h, expected %h", e.name, obs, e.exp);
          end
        end
      end
    end
  end

  // Drive one cycle's inputs just after the edge and queue that cycle's expected word
  task automatic step(input logic clr, input logic r, input logic [31:0] i, input logic care,
                      input logic [25:0] exp, input string name);
    @(posedge clock);
    #1;
    clear   = clr;
    bus.run = r;
    bus.ir  = i;
    sb.push_back('{care, exp, name});
  endtask

  task automatic fetch(input logic [31:0] i, input logic r, input string name);
    step(1'b0, r, i, 1'b1, WT0, {name, "_t0"});
    step(1'b0, r, i, 1'b1, WT1, {name, "_t1"});
    step(1'b0, r, i, 1'b1, WT2, {name, "_t2"});
  endtask

  initial begin
    logic [31:0] i_shr, i_mul, i_add, i_neg, i_not, i_nop, i_hlt, i_ill;
    i_shr = instr(5'd8, 4'd4, 4'd3, 4'd7);
    i_mul = instr(5'd9, 4'd1, 4'd2, 4'd3);
    i_add = instr(5'd0, 4'd5, 4'd1, 4'd2);
    i_neg = instr(5'd11, 4'd6, 4'd7, 4'd0);
    i_not = instr(5'd12, 4'd9, 4'd10, 4'd0);
    i_nop = instr(5'd13, 4'd0, 4'd0, 4'd0);
    i_hlt = instr(5'd14, 4'd0, 4'd0, 4'd0);
    i_ill = instr(5'd20, 4'd0, 4'd0, 4'd0);
    checks  = 0;
    fails   = 0;
    clear   = 1'b1;
    bus.run = 1'b0;
    bus.ir  = 32'd0;

    step(1'b1, 1'b0, 32'd0, 1'b0, WIdle, "clear_cycle");
    step(1'b0, 1'b0, 32'hffff_ffff, 1'b1, WIdle, "reset_idle");
    step(1'b0, 1'b0, 32'hffff_ffff, 1'b1, WIdle, "idle_ignores_ir");

    // shr with run dropped mid-instruction: must still complete, then idle
    step(1'b0, 1'b1, i_shr, 1'b1, WIdle, "shr_idle");
    fetch(i_shr, 1'b0, "shr");
    step(1'b0, 1'b0, i_shr, 1'b1, cw(5'd3, 4'd0, 4'd0, EY, 1'b0, 1'b0), "shr_t3");
    step(1'b0, 1'b0, i_shr, 1'b1, cw(5'd7, 4'd0, 4'd8, EZ, 1'b0, 1'b0), "shr_t4");
    step(1'b0, 1'b0, i_shr, 1'b1, cw(5'd19, 4'd4, 4'd0, EGp, 1'b0, 1'b0), "shr_t5");
    step(1'b0, 1'b0, i_shr, 1'b1, WIdle, "shr_end_idle");
    step(1'b0, 1'b0, i_shr, 1'b1, WIdle, "shr_stay_idle");

    // mul: LO then HI, no GP write
    step(1'b0, 1'b1, i_mul, 1'b1, WIdle, "mul_idle");
    fetch(i_mul, 1'b1, "mul");
    step(1'b0, 1'b1, i_mul, 1'b1, cw(5'd2, 4'd0, 4'd0, EY, 1'b0, 1'b0), "mul_t3");
    step(1'b0, 1'b1, i_mul, 1'b1, cw(5'd3, 4'd0, 4'd9, EZ, 1'b0, 1'b0), "mul_t4");
    step(1'b0, 1'b1, i_mul, 1'b1, cw(5'd19, 4'd0, 4'd0, ELo, 1'b0, 1'b0), "mul_t5");
    step(1'b0, 1'b0, i_mul, 1'b1, cw(5'd18, 4'd0, 4'd0, EHi, 1'b0, 1'b0), "mul_t6");
    step(1'b0, 1'b0, i_mul, 1'b1, WIdle, "mul_end_idle");

    // Back-to-back add then neg: 11 cycles, no bubble between them
    step(1'b0, 1'b1, i_add, 1'b1, WIdle, "b2b_idle");
    fetch(i_add, 1'b1, "add");
    step(1'b0, 1'b1, i_add, 1'b1, cw(5'd1, 4'd0, 4'd0, EY, 1'b0, 1'b0), "add_t3");
    step(1'b0, 1'b1, i_add, 1'b1, cw(5'd2, 4'd0, 4'd0, EZ, 1'b0, 1'b0), "add_t4");
    step(1'b0, 1'b1, i_add, 1'b1, cw(5'd19, 4'd5, 4'd0, EGp, 1'b0, 1'b0), "add_t5");
    fetch(i_neg, 1'b1, "neg");
    step(1'b0, 1'b1, i_neg, 1'b1, cw(5'd7, 4'd0, 4'd11, EZ, 1'b0, 1'b0), "neg_t3");
    step(1'b0, 1'b0, i_neg, 1'b1, cw(5'd19, 4'd6, 4'd0, EGp, 1'b0, 1'b0), "neg_t4");
    step(1'b0, 1'b0, i_neg, 1'b1, WIdle, "b2b_end_idle");

    // Unary not
    step(1'b0, 1'b1, i_not, 1'b1, WIdle, "not_idle");
    fetch(i_not, 1'b0, "not");
    step(1'b0, 1'b0, i_not, 1'b1, cw(5'd10, 4'd0, 4'd12, EZ, 1'b0, 1'b0), "not_t3");
    step(1'b0, 1'b0, i_not, 1'b1, cw(5'd19, 4'd9, 4'd0, EGp, 1'b0, 1'b0), "not_t4");
    step(1'b0, 1'b0, i_not, 1'b1, WIdle, "not_end_idle");

    // Reset during T4 of add with run high: clear wins, no T5
    step(1'b0, 1'b1, i_add, 1'b1, WIdle, "rst_idle");
    fetch(i_add, 1'b1, "rst_add");
    step(1'b0, 1'b1, i_add, 1'b1, cw(5'd1, 4'd0, 4'd0, EY, 1'b0, 1'b0), "rst_add_t3");
    step(1'b1, 1'b1, i_add, 1'b1, cw(5'd2, 4'd0, 4'd0, EZ, 1'b0, 1'b0), "rst_add_t4");
    step(1'b0, 1'b0, i_add, 1'b1, WIdle, "rst_after_clear");
    step(1'b0, 1'b0, i_add, 1'b1, WIdle, "rst_no_gp");

    // clear and run both high in IDLE: stays IDLE, run honoured afterwards
    step(1'b1, 1'b1, i_nop, 1'b1, WIdle, "clr_run_idle");
    step(1'b0, 1'b1, i_nop, 1'b1, WIdle, "clr_run_wins");
    fetch(i_nop, 1'b0, "nop");
    step(1'b0, 1'b0, i_nop, 1'b1, WIdle, "nop_t3");
    step(1'b0, 1'b0, i_nop, 1'b1, WIdle, "nop_end_idle");

    // One-cycle run pulse starts a fetch on the next edge
    step(1'b0, 1'b1, i_nop, 1'b1, WIdle, "pulse_idle");
    fetch(i_nop, 1'b0, "pulse");
    step(1'b0, 1'b0, i_nop, 1'b1, WIdle, "pulse_t3");
    step(1'b0, 1'b0, i_nop, 1'b1, WIdle, "pulse_end_idle");

    // halt opcode: HALT without illegal
    step(1'b0, 1'b1, i_hlt, 1'b1, WIdle, "hlt_idle");
    fetch(i_hlt, 1'b1, "hlt");
    step(1'b0, 1'b1, i_hlt, 1'b1, WIdle, "hlt_t3");
    step(1'b0, 1'b1, i_hlt, 1'b1, cw(5'd0, 4'd0, 4'd0, 11'd0, 1'b1, 1'b0), "hlt_halt");
    step(1'b1, 1'b0, i_hlt, 1'b1, cw(5'd0, 4'd0, 4'd0, 11'd0, 1'b1, 1'b0), "hlt_clr");
    step(1'b0, 1'b0, i_hlt, 1'b1, WIdle, "hlt_cleared");

    // Illegal opcode 20: HALT with illegal, sticky under run, cleared by clear
    step(1'b0, 1'b1, i_ill, 1'b1, WIdle, "ill_idle");
    fetch(i_ill, 1'b1, "ill");
    step(1'b0, 1'b1, i_ill, 1'b1, WIdle, "ill_t3");
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, i_ill, 1'b1, cw(5'd0, 4'd0, 4'd0, 11'd0, 1'b1, 1'b1), "ill_halt");
    end
    step(1'b1, 1'b1, i_ill, 1'b1, cw(5'd0, 4'd0, 4'd0, 11'd0, 1'b1, 1'b1), "ill_clr");
    step(1'b0, 1'b0, i_ill, 1'b1, WIdle, "ill_cleared");
    step(1'b0, 1'b0, i_ill, 1'b1, WIdle, "ill_stay_idle");

    // Let the monitor drain the scoreboard, bounded
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: observed %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
